// File: rtl/aes128_encrypt_core.sv
`default_nettype none
// ============================================================================
// Module      : aes128_encrypt_core
// Description : Iterative AES-128 encryption engine (FIPS-197). One round per
//               clock and round keys generated on the fly. A block takes 11
//               cycles from the start edge to the done pulse.
//               Datapath: initial AddRoundKey at the start edge, nine full
//               rounds (SubBytes, ShiftRows, MixColumns, AddRoundKey), then a
//               last round without MixColumns.
// Ports       : clk          - rising-edge clock
//               rst_n        - asynchronous active-low reset
//               start        - one-cycle request, sampled only when idle
//               Message      - 128-bit plaintext, byte 0 in bits [127:120]
//               Key          - 128-bit cipher key, same byte order
//               busy         - high while a block is in progress
//               done         - one-cycle pulse when cipher is updated
//               cipher       - registered ciphertext, same byte order
//               key_schedule - (KEY_SCHEDULE_OUT_EN only) 11 x 128-bit round
//                              keys, round key r at [1407-128r -: 128]
// Options     : `define KEY_SCHEDULE_OUT_EN adds the key_schedule output.
// Parameters  : NR - number of rounds; only 10 (AES-128) is supported.
// Revision    : 1.0 - initial release
// ============================================================================
module aes128_encrypt_core #(
    parameter int NR = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [127:0]  Message,
    input  logic [127:0]  Key,
    output logic          busy,
    output logic          done,
    output logic [127:0]  cipher
`ifdef KEY_SCHEDULE_OUT_EN
    ,
    output logic [1407:0] key_schedule
`endif
);

    // ------------------------------------------------------------------------
    // Standard AES S-box, indexed by the input byte
    // ------------------------------------------------------------------------
    localparam logic [7:0] c_sbox [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [3:0] c_last_round = 4'(NR);

    // Multiply by x in GF(2^8), reduction polynomial 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Round constant for the key produced while the counter holds 'rnd'
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_e;

    fsm_e         fsm_q,    fsm_d;
    logic [127:0] blk_q,    blk_d;     // AES state between rounds
    logic [127:0] rkey_q,   rkey_d;    // round key used by the previous round
    logic [127:0] cipher_q, cipher_d;
    logic [3:0]   round_q,  round_d;
    logic         done_q,   done_d;

    logic         w_accept;
    logic [127:0] w_sb;        // SubBytes(state)
    logic [127:0] w_sr;        // ShiftRows(SubBytes(state))
    logic [127:0] w_mix;       // MixColumns(ShiftRows(SubBytes(state)))
    logic [31:0]  w_rot;       // RotWord of the last key word
    logic [31:0]  w_ksub;      // SubWord(RotWord)
    logic [31:0]  w_ktmp;
    logic [127:0] w_nkey;      // next round key
    logic [127:0] w_full;
    logic [127:0] w_last;

    assign w_accept = (fsm_q == ST_IDLE) && start;

    // ------------------------------------------------------------------------
    // Round datapath. Byte i of a 128-bit state lives at [127-8i -: 8] and
    // byte i is row (i mod 4), column (i div 4).
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
        assign w_sb[127-8*gi -: 8] = c_sbox[blk_q[127-8*gi -: 8]];
    end

    // Row r rotates left by r columns: out[r][c] = in[r][(c+r) mod 4]
    for (genvar gr = 0; gr < 4; gr++) begin : g_sr_row
        for (genvar gc = 0; gc < 4; gc++) begin : g_sr_col
            assign w_sr[127-8*(gr+4*gc) -: 8] = w_sb[127-8*(gr+4*((gc+gr)%4)) -: 8];
        end
    end

    for (genvar gc = 0; gc < 4; gc++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = w_sr[127-32*gc    -: 8];
        assign a1 = w_sr[127-32*gc-8  -: 8];
        assign a2 = w_sr[127-32*gc-16 -: 8];
        assign a3 = w_sr[127-32*gc-24 -: 8];
        // 3*a is expressed as xtime(a) ^ a
        assign w_mix[127-32*gc    -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign w_mix[127-32*gc-8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign w_mix[127-32*gc-16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign w_mix[127-32*gc-24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    // ------------------------------------------------------------------------
    // On-the-fly key expansion from the previous round key
    // ------------------------------------------------------------------------
    assign w_rot = {rkey_q[23:0], rkey_q[31:24]};

    for (genvar gk = 0; gk < 4; gk++) begin : g_ksub
        assign w_ksub[31-8*gk -: 8] = c_sbox[w_rot[31-8*gk -: 8]];
    end

    assign w_ktmp            = w_ksub ^ {rcon(round_q), 24'h000000};
    assign w_nkey[127:96]    = rkey_q[127:96] ^ w_ktmp;
    assign w_nkey[95:64]     = rkey_q[95:64]  ^ w_nkey[127:96];
    assign w_nkey[63:32]     = rkey_q[63:32]  ^ w_nkey[95:64];
    assign w_nkey[31:0]      = rkey_q[31:0]   ^ w_nkey[63:32];

    assign w_full = w_mix ^ w_nkey;
    assign w_last = w_sr  ^ w_nkey;

    // ------------------------------------------------------------------------
    // Control: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        fsm_d    = fsm_q;
        blk_d    = blk_q;
        rkey_d   = rkey_q;
        cipher_d = cipher_q;
        round_d  = round_q;
        done_d   = 1'b0;

        case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    blk_d   = Message ^ Key;
                    rkey_d  = Key;
                    round_d = 4'd1;
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                rkey_d = w_nkey;
                if (round_q == c_last_round) begin
                    cipher_d = w_last;
                    done_d   = 1'b1;
                    round_d  = 4'd0;
                    fsm_d    = ST_IDLE;
                end else begin
                    blk_d   = w_full;
                    round_d = round_q + 4'd1;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= ST_IDLE;
            blk_q    <= '0;
            rkey_q   <= '0;
            cipher_q <= '0;
            round_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            blk_q    <= blk_d;
            rkey_q   <= rkey_d;
            cipher_q <= cipher_d;
            round_q  <= round_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (fsm_q == ST_RUN);
    assign done   = done_q;
    assign cipher = cipher_q;

`ifdef KEY_SCHEDULE_OUT_EN
    // ------------------------------------------------------------------------
    // Round-key history: slot 0 is loaded with Key at the start edge, slot r
    // with the key generated at edge r. Slots hold after the block ends.
    // ------------------------------------------------------------------------
    for (genvar gs = 0; gs < NR + 1; gs++) begin : g_ks_slot
        logic         we;
        logic [127:0] slot_q, slot_d;

        if (gs == 0) begin : g_slot_key
            assign we = w_accept;
        end else begin : g_slot_round
            assign we = (fsm_q == ST_RUN) && (round_q == 4'(gs));
        end

        always_comb begin
            slot_d = slot_q;
            if (we) begin
                slot_d = (gs == 0) ? Key : w_nkey;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_q <= '0;
            end else begin
                slot_q <= slot_d;
            end
        end

        assign key_schedule[1407-128*gs -: 128] = slot_q;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes128_encrypt_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes128_encrypt_core
// Description : Self-checking bench for aes128_encrypt_core. The reference
//               AES model builds its S-box from the GF(2^8) inverse plus the
//               affine transform and runs the cipher on byte arrays.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes128_encrypt_core;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [127:0]  Message = '0;
    logic [127:0]  Key = '0;
    logic          busy;
    logic          done;
    logic [127:0]  cipher;
`ifdef KEY_SCHEDULE_OUT_EN
    logic [1407:0] key_schedule;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0] sbox_m [256];

    always #5 clk = ~clk;

    aes128_encrypt_core #(.NR(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .Message      (Message),
        .Key          (Key),
        .busy         (busy),
        .done         (done),
        .cipher       (cipher)
`ifdef KEY_SCHEDULE_OUT_EN
        ,
        .key_schedule (key_schedule)
`endif
    );

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] av, bv, inv, x, r;
        for (int a = 0; a < 256; a++) begin
            av  = 8'(a);
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                bv = 8'(b);
                if (gf_mul(av, bv) == 8'h01) inv = bv;
            end
            x = inv;
            r = inv;
            for (int n = 0; n < 4; n++) begin
                x = {x[6:0], x[7]};
                r = r ^ x;
            end
            sbox_m[av] = r ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_round_key(input logic [127:0] key, input int rnd);
        logic [31:0]  w [44];
        logic [127:0] k = key;
        logic [7:0]   rc = 8'h01;
        logic [31:0]  t;
        for (int i = 0; i < 4; i++) begin
            w[i] = k[127:96];
            k = k << 32;
        end
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] msg, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] m = msg;
        logic [127:0] rk;
        logic [127:0] out = '0;
        for (int i = 0; i < 16; i++) begin
            s[i] = m[127:120];
            m = m << 8;
        end
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
                for (int row = 0; row < 4; row++)
                    for (int col = 0; col < 4; col++)
                        t[row + 4*col] = s[row + 4*((col + row) % 4)];
                s = t;
                if (r < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
                        s[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
                    end
                end
            end
            rk = ref_round_key(key, r);
            for (int i = 0; i < 16; i++) begin
                s[i] = s[i] ^ rk[127:120];
                rk = rk << 8;
            end
        end
        for (int i = 0; i < 16; i++) out = {out[119:0], s[i]};
        return out;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // ------------------------------------------------------------------------
    // Presents a block at one negedge so the next rising edge (E0) accepts
    // it; returns at the negedge after E0.
    task automatic start_block(input logic [127:0] m, input logic [127:0] k);
        @(negedge clk);
        Message = m;
        Key     = k;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Counts negedges until done is seen; cyc starts at 'from'. Bounded.
    task automatic wait_done(input int from, input bit scramble, output int cyc);
        cyc = from;
        while (done !== 1'b1 && cyc < 40) begin
            if (scramble) begin
                Message = rand128();
                Key     = rand128();
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        tests++; if (cipher !== 128'h0) begin fails++; $display("FAIL reset_cipher: got %h expected 0", cipher); end
`ifdef KEY_SCHEDULE_OUT_EN
        tests++; if (key_schedule !== 1408'h0) begin fails++; $display("FAIL reset_key_schedule: not all zero"); end
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_known_answers();
        logic [127:0] kv_key [3];
        logic [127:0] kv_msg [3];
        logic [127:0] kv_exp [3];
        int lat;
        kv_key[0] = 128'h5468617473206D79204B756E67204675;
        kv_msg[0] = 128'h54776F204F6E65204E696E652054776F;
        kv_exp[0] = 128'h29C3505F571420F6402299B31A02D73A;
        kv_key[1] = 128'h000102030405060708090A0B0C0D0E0F;
        kv_msg[1] = 128'h00112233445566778899AABBCCDDEEFF;
        kv_exp[1] = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
        kv_key[2] = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
        kv_msg[2] = 128'h3243F6A8885A308D313198A2E0370734;
        kv_exp[2] = 128'h3925841D02DC09FBDC118597196A0B32;
        for (int v = 0; v < 3; v++) begin
            start_block(kv_msg[v], kv_key[v]);
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL kat%0d_busy: got %b expected 1", v, busy); end
            // third vector also checks that inputs are not re-sampled mid-block
            wait_done(1, (v == 2), lat);
            tests++; if (lat !== 11) begin fails++; $display("FAIL kat%0d_latency: got %0d expected 11", v, lat); end
            tests++; if (cipher !== kv_exp[v]) begin fails++; $display("FAIL kat%0d_cipher: got %h expected %h", v, cipher, kv_exp[v]); end
            tests++; if (cipher !== ref_encrypt(kv_msg[v], kv_key[v])) begin fails++; $display("FAIL kat%0d_model: got %h expected %h", v, cipher, ref_encrypt(kv_msg[v], kv_key[v])); end
            @(negedge clk);
            tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL kat%0d_after: got done=%b busy=%b expected 0 0", v, done, busy); end
            tests++; if (cipher !== kv_exp[v]) begin fails++; $display("FAIL kat%0d_hold: got %h expected %h", v, cipher, kv_exp[v]); end
        end
    endtask

    task automatic test_random();
        logic [127:0] m, k, exp;
        int lat;
        for (int n = 0; n < 6; n++) begin
            m = rand128();
            k = rand128();
            exp = ref_encrypt(m, k);
            start_block(m, k);
            wait_done(1, 1'b0, lat);
            tests++; if (lat !== 11) begin fails++; $display("FAIL rand%0d_latency: got %0d expected 11", n, lat); end
            tests++; if (cipher !== exp) begin fails++; $display("FAIL rand%0d_cipher: got %h expected %h", n, cipher, exp); end
        end
    endtask

    task automatic test_ignored_start();
        logic [127:0] m, k, exp;
        int lat, ndone;
        m = rand128();
        k = rand128();
        exp = ref_encrypt(m, k);
        start_block(m, k);
        repeat (4) @(negedge clk);
        start   = 1'b1;               // sampled at E5 while busy
        Message = rand128();
        Key     = rand128();
        @(negedge clk);
        start   = 1'b0;
        wait_done(6, 1'b0, lat);
        tests++; if (lat !== 11) begin fails++; $display("FAIL ignore_latency: got %0d expected 11", lat); end
        tests++; if (cipher !== exp) begin fails++; $display("FAIL ignore_cipher: got %h expected %h", cipher, exp); end
        ndone = 0;
        repeat (14) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        tests++; if (ndone !== 0) begin fails++; $display("FAIL ignore_extra_done: got %0d expected 0", ndone); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ignore_busy: got %b expected 0", busy); end
        tests++; if (cipher !== exp) begin fails++; $display("FAIL ignore_hold: got %h expected %h", cipher, exp); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] ma, ka, mb, kb, ea, eb;
        int lat;
        ma = rand128(); ka = rand128(); ea = ref_encrypt(ma, ka);
        mb = rand128(); kb = rand128(); eb = ref_encrypt(mb, kb);
        start_block(ma, ka);
        wait_done(1, 1'b0, lat);
        tests++; if (lat !== 11) begin fails++; $display("FAIL b2b_first_latency: got %0d expected 11", lat); end
        // start raised while done is high
        Message = mb;
        Key     = kb;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", busy, done); end
        tests++; if (cipher !== ea) begin fails++; $display("FAIL b2b_first_cipher: got %h expected %h", cipher, ea); end
        wait_done(1, 1'b0, lat);
        tests++; if (lat !== 11) begin fails++; $display("FAIL b2b_second_latency: got %0d expected 11", lat); end
        tests++; if (cipher !== eb) begin fails++; $display("FAIL b2b_second_cipher: got %h expected %h", cipher, eb); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] m, k, exp;
        int lat, ndone;
        start_block(rand128(), rand128());
        repeat (5) @(negedge clk);
        @(posedge clk);               // E6
        #1 rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL midreset_done: got %b expected 0", done); end
        tests++; if (cipher !== 128'h0) begin fails++; $display("FAIL midreset_cipher: got %h expected 0", cipher); end
`ifdef KEY_SCHEDULE_OUT_EN
        tests++; if (key_schedule !== 1408'h0) begin fails++; $display("FAIL midreset_key_schedule: not all zero"); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        tests++; if (ndone !== 0) begin fails++; $display("FAIL midreset_no_done: got %0d expected 0", ndone); end
        m = rand128();
        k = rand128();
        exp = ref_encrypt(m, k);
        start_block(m, k);
        wait_done(1, 1'b0, lat);
        tests++; if (lat !== 11) begin fails++; $display("FAIL midreset_restart_latency: got %0d expected 11", lat); end
        tests++; if (cipher !== exp) begin fails++; $display("FAIL midreset_restart_cipher: got %h expected %h", cipher, exp); end
    endtask

`ifdef KEY_SCHEDULE_OUT_EN
    task automatic test_key_schedule();
        logic [127:0]  k, m, slot, exp;
        logic [1407:0] ks;
        int lat;
        k = 128'h5468617473206D79204B756E67204675;
        m = rand128();
        start_block(m, k);
        wait_done(1, 1'b0, lat);
        repeat (3) @(negedge clk);    // slots must hold after done
        ks = key_schedule;
        for (int r = 0; r <= 10; r++) begin
            slot = ks[1407:1280];
            ks   = ks << 128;
            exp  = ref_round_key(k, r);
            tests++; if (slot !== exp) begin fails++; $display("FAIL ks_slot%0d: got %h expected %h", r, slot, exp); end
            if (r == 1) begin
                tests++; if (slot !== 128'hE232FCF191129188B159E4E6D679A293) begin fails++; $display("FAIL ks_rk1: got %h expected E232FCF191129188B159E4E6D679A293", slot); end
            end
            if (r == 10) begin
                tests++; if (slot !== 128'h28FDDEF86DA4244ACCC0A4FE3B316F26) begin fails++; $display("FAIL ks_rk10: got %h expected 28FDDEF86DA4244ACCC0A4FE3B316F26", slot); end
            end
        end
    endtask
`endif

    initial begin
        build_sbox();
        test_reset();
        test_known_answers();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
`ifdef KEY_SCHEDULE_OUT_EN
        test_key_schedule();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
